// File: rtl/rr_arb_pkg.sv
// Shared types and default constants for the round-robin arbiter.
// Imported by rr_pick_comb and rr_arbiter_fsm.
package rr_arb_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } arb_state_e;

   localparam int DEF_NUM_REQ  = 4;
   localparam int DEF_MAX_HOLD = 8;

endpackage

// File: rtl/rr_pick_comb.sv
// Combinational rotate-priority encoder: first set bit of (req & mask)
// scanning last+1, last+2, ... with wrap at NUM_REQ (not at 2^ID_W).
module rr_pick_comb
   import rr_arb_pkg::*;
#(
   parameter int NUM_REQ = DEF_NUM_REQ,
   parameter int ID_W    = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [ID_W-1:0]    last,
   input  logic [NUM_REQ-1:0] mask,
   output logic               found,
   output logic [ID_W-1:0]    pick_id
);

   logic [NUM_REQ-1:0] eff;

   assign eff = req & mask;

   // Scan from the farthest offset down so the nearest candidate wins last.
   always_comb begin
      int idx;
      found   = 1'b0;
      pick_id = '0;
      idx     = 0;
      for (int i = NUM_REQ; i >= 1; i--) begin
         idx = (int'(last) + i) % NUM_REQ;
         if (eff[idx]) begin
            found   = 1'b1;
            pick_id = ID_W'(idx);
         end
      end
   end

endmodule

// File: rtl/rr_arbiter_fsm.sv
// Round-robin arbiter with registered one-hot grants and a bounded tenure.
// Optional owner lock that suppresses tenure preemption: define RR_ARB_LOCK_EN.
//
// Handshake: a requester holds req[i] high until it sees gnt[i]; it keeps
// ownership while req[i] stays high, and releases by dropping req[i]. The
// grant for a request sampled at edge N is visible after edge N.
module rr_arbiter_fsm
   import rr_arb_pkg::*;
#(
   parameter int NUM_REQ  = DEF_NUM_REQ,
   parameter int MAX_HOLD = DEF_MAX_HOLD,
   parameter int ID_W     = $clog2(NUM_REQ),
   parameter int HC_W     = $clog2(MAX_HOLD + 1)
) (
   input  logic               clock,
   input  logic               reset,
   input  logic [NUM_REQ-1:0] req,
`ifdef RR_ARB_LOCK_EN
   input  logic               lock,
`endif
   output logic [NUM_REQ-1:0] gnt,
   output logic               gnt_valid,
   output logic [ID_W-1:0]    gnt_id,
   output logic [HC_W-1:0]    hold_cnt,
   output arb_state_e         state
);

   logic [ID_W-1:0]    last_q;
   logic [ID_W-1:0]    pick_last;
   logic [NUM_REQ-1:0] pick_mask;
   logic               pick_found;
   logic [ID_W-1:0]    pick_id;
   logic [NUM_REQ-1:0] pick_oh;
   logic [NUM_REQ-1:0] owner_oh;
   logic               owner_req;
   logic               at_limit;
   logic               lock_hold;

`ifdef RR_ARB_LOCK_EN
   assign lock_hold = lock;
`else
   assign lock_hold = 1'b0;
`endif

   // While granting, the owner is excluded and the scan starts just after it.
   always_comb begin
      owner_oh  = NUM_REQ'(1) << gnt_id;
      owner_req = |(req & owner_oh);
      at_limit  = (hold_cnt >= HC_W'(MAX_HOLD));
      pick_oh   = NUM_REQ'(1) << pick_id;
      if (state == GRANT) begin
         pick_last = gnt_id;
         pick_mask = ~owner_oh;
      end else begin
         pick_last = last_q;
         pick_mask = '1;
      end
   end

   rr_pick_comb #(
      .NUM_REQ (NUM_REQ),
      .ID_W    (ID_W)
   ) u_pick (
      .req     (req),
      .last    (pick_last),
      .mask    (pick_mask),
      .found   (pick_found),
      .pick_id (pick_id)
   );

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         gnt       <= '0;
         gnt_valid <= 1'b0;
         gnt_id    <= '0;
         hold_cnt  <= '0;
         last_q    <= ID_W'(NUM_REQ - 1);
      end else begin
         case (state)
            IDLE: begin
               if (pick_found) begin
                  state     <= GRANT;
                  gnt       <= pick_oh;
                  gnt_valid <= 1'b1;
                  gnt_id    <= pick_id;
                  last_q    <= pick_id;
                  hold_cnt  <= HC_W'(1);
               end
            end
            GRANT: begin
               if (!owner_req) begin
                  if (pick_found) begin
                     gnt      <= pick_oh;
                     gnt_id   <= pick_id;
                     last_q   <= pick_id;
                     hold_cnt <= HC_W'(1);
                  end else begin
                     // gnt_id keeps the last owner while idle.
                     state     <= IDLE;
                     gnt       <= '0;
                     gnt_valid <= 1'b0;
                     hold_cnt  <= '0;
                  end
               end else if (!at_limit) begin
                  hold_cnt <= hold_cnt + HC_W'(1);
               end else if (pick_found && !lock_hold) begin
                  gnt      <= pick_oh;
                  gnt_id   <= pick_id;
                  last_q   <= pick_id;
                  hold_cnt <= HC_W'(1);
               end
               // Otherwise the owner keeps the grant and hold_cnt stays saturated.
            end
            default: begin
               state     <= IDLE;
               gnt       <= '0;
               gnt_valid <= 1'b0;
               hold_cnt  <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_rr_arbiter_fsm.sv
// Directed bench for rr_arbiter_fsm with NUM_REQ=4, MAX_HOLD=4.
// Lock scenario is compiled in when RR_ARB_LOCK_EN is defined.
module tb_rr_arbiter_fsm;
   import rr_arb_pkg::*;

   localparam int NUM_REQ  = 4;
   localparam int MAX_HOLD = 4;
   localparam int ID_W     = $clog2(NUM_REQ);
   localparam int HC_W     = $clog2(MAX_HOLD + 1);

   logic               clock;
   logic               reset;
   logic [NUM_REQ-1:0] req;
`ifdef RR_ARB_LOCK_EN
   logic               lock;
`endif
   logic [NUM_REQ-1:0] gnt;
   logic               gnt_valid;
   logic [ID_W-1:0]    gnt_id;
   logic [HC_W-1:0]    hold_cnt;
   arb_state_e         state;

   int tests_run;
   int tests_failed;

   rr_arbiter_fsm #(
      .NUM_REQ  (NUM_REQ),
      .MAX_HOLD (MAX_HOLD)
   ) dut (
      .clock     (clock),
      .reset     (reset),
      .req       (req),
`ifdef RR_ARB_LOCK_EN
      .lock      (lock),
`endif
      .gnt       (gnt),
      .gnt_valid (gnt_valid),
      .gnt_id    (gnt_id),
      .hold_cnt  (hold_cnt),
      .state     (state)
   );

   // Clock / reset block
   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   // One clock edge, then sample 1 ns later.
   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b0;
      req   = '0;
      step();
      reset = 1'b1;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      req   = 4'b1111;
      for (int c = 0; c < 2; c++) begin
         step();
         tests_run++;
         if (gnt !== 4'b0000) begin
            tests_failed++;
            $display("FAIL reset_gnt cycle %0d: got %b exp 0000", c, gnt);
         end
      end
      tests_run++;
      if (gnt_valid !== 1'b0 || gnt_id !== 2'd0 || hold_cnt !== 3'd0 || state !== IDLE) begin
         tests_failed++;
         $display("FAIL reset_outputs: got valid=%b id=%0d hold=%0d state=%0d exp 0/0/0/0",
                  gnt_valid, gnt_id, hold_cnt, state);
      end
      reset = 1'b1;
      step();
      tests_run++;
      if (gnt !== 4'b0001 || gnt_id !== 2'd0 || hold_cnt !== 3'd1 || gnt_valid !== 1'b1) begin
         tests_failed++;
         $display("FAIL reset_release: got gnt=%b id=%0d hold=%0d valid=%b exp 0001/0/1/1",
                  gnt, gnt_id, hold_cnt, gnt_valid);
      end
   endtask

   // Continues from test_reset: req=1111, cycle 0 of tenure 0 already seen.
   task automatic test_rotation();
      logic [NUM_REQ-1:0] exp_gnt;
      logic [HC_W-1:0]    exp_hold;
      int                 ten;
      req = 4'b1111;
      for (int c = 1; c <= 16; c++) begin
         step();
         ten      = (c / MAX_HOLD) % NUM_REQ;
         exp_gnt  = NUM_REQ'(1) << ten;
         exp_hold = HC_W'((c % MAX_HOLD) + 1);
         tests_run++;
         if (gnt !== exp_gnt || hold_cnt !== exp_hold || gnt_id !== ID_W'(ten)) begin
            tests_failed++;
            $display("FAIL rotation cycle %0d: got gnt=%b hold=%0d id=%0d exp gnt=%b hold=%0d id=%0d",
                     c, gnt, hold_cnt, gnt_id, exp_gnt, exp_hold, ten);
         end
      end
   endtask

   task automatic test_handoff();
      do_reset();
      req = 4'b0010;
      step();
      tests_run++;
      if (gnt !== 4'b0010 || gnt_id !== 2'd1) begin
         tests_failed++;
         $display("FAIL handoff_setup: got gnt=%b id=%0d exp 0010/1", gnt, gnt_id);
      end
      req = 4'b1001;
      step();
      tests_run++;
      if (gnt !== 4'b1000 || gnt_id !== 2'd3 || hold_cnt !== 3'd1 || gnt_valid !== 1'b1) begin
         tests_failed++;
         $display("FAIL handoff: got gnt=%b id=%0d hold=%0d valid=%b exp 1000/3/1/1",
                  gnt, gnt_id, hold_cnt, gnt_valid);
      end
   endtask

   // Owner 3 drops, requester 2 alone takes over and saturates.
   task automatic test_lone();
      logic [HC_W-1:0] exp_hold;
      req = 4'b0100;
      for (int c = 1; c <= 10; c++) begin
         step();
         exp_hold = (c < MAX_HOLD) ? HC_W'(c) : HC_W'(MAX_HOLD);
         tests_run++;
         if (gnt !== 4'b0100 || hold_cnt !== exp_hold) begin
            tests_failed++;
            $display("FAIL lone cycle %0d: got gnt=%b hold=%0d exp 0100/%0d",
                     c, gnt, hold_cnt, exp_hold);
         end
      end
   endtask

   task automatic test_idle();
      req = 4'b0000;
      step();
      tests_run++;
      if (gnt !== 4'b0000 || gnt_valid !== 1'b0 || gnt_id !== 2'd2 ||
          hold_cnt !== 3'd0 || state !== IDLE) begin
         tests_failed++;
         $display("FAIL idle: got gnt=%b valid=%b id=%0d hold=%0d state=%0d exp 0000/0/2/0/0",
                  gnt, gnt_valid, gnt_id, hold_cnt, state);
      end
      step();
      tests_run++;
      if (gnt !== 4'b0000 || gnt_id !== 2'd2) begin
         tests_failed++;
         $display("FAIL idle_stay: got gnt=%b id=%0d exp 0000/2", gnt, gnt_id);
      end
   endtask

   task automatic test_reset_mid();
      req = 4'b0100;
      step();
      tests_run++;
      if (gnt !== 4'b0100) begin
         tests_failed++;
         $display("FAIL reset_mid_setup: got gnt=%b exp 0100", gnt);
      end
      reset = 1'b0;
      #2;
      tests_run++;
      if (gnt !== 4'b0000 || gnt_valid !== 1'b0 || gnt_id !== 2'd0) begin
         tests_failed++;
         $display("FAIL reset_async: got gnt=%b valid=%b id=%0d exp 0000/0/0",
                  gnt, gnt_valid, gnt_id);
      end
      step();
      reset = 1'b1;
      req   = 4'b1111;
      step();
      tests_run++;
      if (gnt !== 4'b0001 || gnt_id !== 2'd0) begin
         tests_failed++;
         $display("FAIL reset_restart: got gnt=%b id=%0d exp 0001/0", gnt, gnt_id);
      end
   endtask

`ifdef RR_ARB_LOCK_EN
   task automatic test_lock();
      do_reset();
      lock = 1'b1;
      req  = 4'b0011;
      for (int c = 1; c <= 8; c++) begin
         step();
         tests_run++;
         if (gnt !== 4'b0001) begin
            tests_failed++;
            $display("FAIL lock_hold cycle %0d: got gnt=%b exp 0001", c, gnt);
         end
      end
      tests_run++;
      if (hold_cnt !== HC_W'(MAX_HOLD)) begin
         tests_failed++;
         $display("FAIL lock_saturate: got hold=%0d exp %0d", hold_cnt, MAX_HOLD);
      end
      lock = 1'b0;
      step();
      tests_run++;
      if (gnt !== 4'b0010 || hold_cnt !== 3'd1) begin
         tests_failed++;
         $display("FAIL lock_release: got gnt=%b hold=%0d exp 0010/1", gnt, hold_cnt);
      end
      req = 4'b0000;
   endtask
`endif

   initial begin
      tests_run    = 0;
      tests_failed = 0;
      reset        = 1'b0;
      req          = '0;
`ifdef RR_ARB_LOCK_EN
      lock         = 1'b0;
`endif
      test_reset();
      test_rotation();
      test_handoff();
      test_lone();
      test_idle();
      test_reset_mid();
`ifdef RR_ARB_LOCK_EN
      test_lock();
`endif
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/rr_arbiter_fsm.md
Name: rr_arbiter_fsm

Overview:
- Parametrised successor to the team's 2-requester grant FSM.
- Arbitrates NUM_REQ requesters with round-robin fairness, registered one-hot grants, and a bounded grant-hold (tenure) limit.
- Sits between bus/resource requesters and a shared resource.
- Grant is held while the owner keeps requesting; the owner is preempted only when the hold limit expires and another requester is waiting.

Parameters:
- NUM_REQ, 4: number of requesters; legal range 2..16.
- MAX_HOLD, 8: maximum consecutive grant cycles per tenure when others are waiting; legal range >=1.
- ID_W, $clog2(NUM_REQ): width of the grant index (derived; not overridden).

Ports:
- clock  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- req  input  NUM_REQ  request vector; bit i = requester i.
- gnt  output  NUM_REQ  registered one-hot grant; all zero when idle.
- gnt_valid  output  1  high when any grant is active (OR of gnt, registered).
- gnt_id  output  ID_W  index of current owner; holds the last owner while idle.
- hold_cnt  output  $clog2(MAX_HOLD+1)  cycles elapsed in the current tenure (debug/observability).

Behaviour:
- Reset (reset=0, asynchronous):
  - gnt=0, gnt_valid=0, gnt_id=0, hold_cnt=0, state=IDLE.
  - Round-robin pointer last=NUM_REQ-1, so requester 0 has top priority after reset.
- States: IDLE, GRANT.
- Selection function rr_pick(req, last): the first set bit scanning last+1, last+2, ... wrapping modulo NUM_REQ. Ties are impossible.
- IDLE:
  - If |req at the clock edge -> GRANT; gnt=onehot(rr_pick); gnt_id=pick; last=pick; hold_cnt=1.
  - Otherwise stay in IDLE; outputs stay zero.
  - Latency: request sampled at edge N, grant visible after edge N (one registered cycle).
- GRANT, owner o:
  - req[o]=0, other requests pending -> grant rr_pick(req & ~onehot(o), o) at the same edge. No idle bubble; hold_cnt=1.
  - req[o]=0, no others pending -> IDLE; gnt=0, gnt_valid=0, gnt_id retains o, hold_cnt=0.
  - req[o]=1, hold_cnt<MAX_HOLD -> keep o; hold_cnt+1.
  - req[o]=1, hold_cnt==MAX_HOLD, another req pending -> preempt: grant rr_pick excluding o; hold_cnt=1.
  - req[o]=1, hold_cnt==MAX_HOLD, no others pending -> keep o; hold_cnt saturates at MAX_HOLD (no wrap).
- Invariants: gnt is always one-hot or zero. gnt_valid==|gnt. gnt[i] is never asserted unless req[i] was high at the granting edge.
- Fairness: any continuously asserted request is granted within (NUM_REQ-1)*MAX_HOLD+1 cycles.
- Reset mid-tenure: grant drops immediately (asynchronously). Arbitration restarts with requester 0 priority.
- NUM_REQ not a power of two: pointer arithmetic wraps at NUM_REQ, not at 2^ID_W.

Optional Feature:
- Macro: RR_ARB_LOCK_EN.
- Defined:
  - Adds input port lock (1 bit).
  - While the owner holds lock=1 together with req[o]=1, the MAX_HOLD preemption is suppressed and hold_cnt saturates.
  - When lock falls, preemption is evaluated at the next edge with the saturated count, so a waiting requester takes over at once.
  - lock is ignored in IDLE.
- Undefined: no lock port; MAX_HOLD always applies.

Decomposition:
- Package rr_arb_pkg holds:
  - state enum arb_state_e {IDLE, GRANT}.
  - Default constants DEF_NUM_REQ=4 and DEF_MAX_HOLD=8.
- One sub-module, rr_pick_comb: purely combinational rotate-priority encoder.
  - Inputs: req, last, mask.
  - Outputs: found, pick_id.
- The FSM, counter and pointer live in rr_arbiter_fsm.

Test Plan (NUM_REQ=4, MAX_HOLD=4 unless noted):
- Reset release: hold reset low 2 cycles with req=4'b1111 -> gnt=0 throughout reset; first edge after release gives gnt=4'b0001, gnt_id=0.
- Rotation:
  - req=4'b1111 held constant -> gnt sequence 0001 (4 cycles), 0010 (4), 0100 (4), 1000 (4), then 0001.
  - hold_cnt counts 1..4 in each tenure.
- Early release handoff:
  - Owner 1 active, then req goes 4'b0010 -> 4'b1001 at one edge -> next gnt=4'b0100? No: 4'b1000 (index 3 is first after 1 among set bits {0,3}).
  - No zero cycle between grants.
- Lone requester: req=4'b0100 for 10 cycles -> gnt=4'b0100 for all cycles; hold_cnt saturates at 4.
- Idle and reset mid-operation:
  - req drops to 0 -> gnt=0, gnt_valid=0, gnt_id unchanged.
  - Asserting reset while gnt=4'b0100 -> gnt=0 without waiting for a clock edge.
- Lock (RR_ARB_LOCK_EN): owner 0 with lock=1 and req=4'b0011 for 8 cycles -> gnt stays 0001; lock falls -> gnt=0010 at the next edge.
